// File: rtl/frogger_mailbox_master.sv
// Avalon-MM master for the shared mailbox RAM: sweeps all words into a snapshot bank on request
// and performs single-word byte-enabled writes, scheduling around a fixed-latency slave.
module frogger_mailbox_master #(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sweep_req,
  input  logic                            wr_req,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [DATA_W/8-1:0]             wr_be,
  output logic [ADDR_W-1:0]               avm_address,
  output logic [DATA_W/8-1:0]             avm_byteenable,
  output logic                            avm_chipselect,
  output logic                            avm_write,
  output logic [DATA_W-1:0]               avm_writedata,
  output logic                            avm_clken,
  input  logic [DATA_W-1:0]               avm_readdata,
  output logic [DATA_W*(2**ADDR_W)-1:0]   snap_flat,
  output logic                            snap_valid,
  output logic                            wr_done,
  output logic                            busy
);

  localparam int unsigned Words = 2 ** ADDR_W;
  localparam int unsigned BeW   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LastAddr = '1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic                    sweep_pend_q, sweep_pend_d;
  logic                    wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic [BeW-1:0]          wr_be_q, wr_be_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [BeW-1:0]          be_q, be_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W*Words-1:0] snap_q, snap_d;
  logic                    snap_valid_q, snap_valid_d;
  logic                    wr_done_q, wr_done_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [ADDR_W-1:0]       pa_q [READ_LATENCY];
  logic [ADDR_W-1:0]       pa_d [READ_LATENCY];
  logic                    push;

  always_comb begin
    state_d      = state_q;
    sweep_pend_d = sweep_pend_q;
    wr_pend_d    = wr_pend_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_be_d      = wr_be_q;
    addr_d       = addr_q;
    be_d         = be_q;
    cs_d         = cs_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    snap_d       = snap_q;
    snap_valid_d = 1'b0;
    wr_done_d    = 1'b0;
    push         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_pend_q) begin
          state_d   = StWrite;
          wr_pend_d = 1'b0;
          cs_d      = 1'b1;
          we_d      = 1'b1;
          addr_d    = wr_addr_q;
          wdata_d   = wr_data_q;
          be_d      = wr_be_q;
          wr_done_d = 1'b1;
        end else if (sweep_pend_q) begin
          state_d      = StRead;
          sweep_pend_d = 1'b0;
          cs_d         = 1'b1;
          we_d         = 1'b0;
          addr_d       = '0;
          be_d         = '1;
        end
      end
      StWrite: begin
        state_d = StIdle;
        cs_d    = 1'b0;
        we_d    = 1'b0;
      end
      StRead: begin
        if (cs_q) begin
          push = 1'b1;
          if (addr_q == LastAddr) cs_d = 1'b0;
          else addr_d = addr_q + ADDR_W'(1);
        end
        // Completion keys off the last address leaving the read pipeline, not on wrap.
        if (pv_q[READ_LATENCY-1] && pa_q[READ_LATENCY-1] == LastAddr) begin
          snap_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (pv_q[READ_LATENCY-1]) begin
      snap_d[pa_q[READ_LATENCY-1]*DATA_W +: DATA_W] = avm_readdata;
    end

    // New requests win over the launch-time clear.
    if (sweep_req) sweep_pend_d = 1'b1;
    if (wr_req) begin
      wr_pend_d = 1'b1;
      wr_addr_d = wr_addr;
      wr_data_d = wr_data;
      wr_be_d   = wr_be;
    end

    pa_d = pa_q;
    pv_d = pv_q;
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
    end
    pv_d[0] = push;
    pa_d[0] = addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      sweep_pend_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_be_q      <= '0;
      addr_q       <= '0;
      be_q         <= '1;
      cs_q         <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
      wr_done_q    <= 1'b0;
      pv_q         <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pa_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      sweep_pend_q <= sweep_pend_d;
      wr_pend_q    <= wr_pend_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_be_q      <= wr_be_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      cs_q         <= cs_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
      wr_done_q    <= wr_done_d;
      pv_q         <= pv_d;
      for (int i = 0; i < READ_LATENCY; i++) pa_q[i] <= pa_d[i];
    end
  end

  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_chipselect = cs_q;
  assign avm_write      = we_q;
  assign avm_writedata  = wdata_q;
  assign avm_clken      = 1'b1;
  assign snap_flat      = snap_q;
  assign snap_valid     = snap_valid_q;
  assign wr_done        = wr_done_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_frogger_mailbox_master.sv
// Directed bench: two masters (read latency 1 and 2) each driving a behavioural mailbox RAM.
module tb_frogger_mailbox_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;

  // Master 1 (READ_LATENCY=1)
  logic        sweep_req1 = 1'b0, wr_req1 = 1'b0;
  logic [1:0]  wr_addr1 = '0;
  logic [31:0] wr_data1 = '0;
  logic [3:0]  wr_be1 = '0;
  logic [1:0]  a1;
  logic [3:0]  be1;
  logic        cs1, we1, ck1, sv1, done1, busy1;
  logic [31:0] wd1, rd1;
  logic [127:0] flat1;
  logic [31:0] mem1 [4];

  // Master 2 (READ_LATENCY=2)
  logic        sweep_req2 = 1'b0, wr_req2 = 1'b0;
  logic [1:0]  wr_addr2 = '0;
  logic [31:0] wr_data2 = '0;
  logic [3:0]  wr_be2 = '0;
  logic [1:0]  a2;
  logic [3:0]  be2;
  logic        cs2, we2, ck2, sv2, done2, busy2;
  logic [31:0] wd2, rd2, rd2a;
  logic [127:0] flat2;
  logic [31:0] mem2 [4];

  frogger_mailbox_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .sweep_req(sweep_req1), .wr_req(wr_req1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .wr_be(wr_be1), .avm_address(a1), .avm_byteenable(be1),
    .avm_chipselect(cs1), .avm_write(we1), .avm_writedata(wd1), .avm_clken(ck1),
    .avm_readdata(rd1), .snap_flat(flat1), .snap_valid(sv1), .wr_done(done1), .busy(busy1)
  );

  frogger_mailbox_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .sweep_req(sweep_req2), .wr_req(wr_req2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .wr_be(wr_be2), .avm_address(a2), .avm_byteenable(be2),
    .avm_chipselect(cs2), .avm_write(we2), .avm_writedata(wd2), .avm_clken(ck2),
    .avm_readdata(rd2), .snap_flat(flat2), .snap_valid(sv2), .wr_done(done2), .busy(busy2)
  );

  // Mailbox RAM models, preloaded on reset.
  always @(posedge clk) begin
    if (reset) begin
      mem1[0] <= 32'h11111111; mem1[1] <= 32'h22222222;
      mem1[2] <= 32'h33333333; mem1[3] <= 32'h44444444;
      rd1 <= '0;
    end else if (cs1) begin
      if (we1) begin
        for (int b = 0; b < 4; b++) if (be1[b]) mem1[a1][b*8 +: 8] <= wd1[b*8 +: 8];
      end else begin
        rd1 <= mem1[a1];
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      mem2[0] <= 32'h11111111; mem2[1] <= 32'h22222222;
      mem2[2] <= 32'h33333333; mem2[3] <= 32'h44444444;
      rd2a <= '0;
      rd2  <= '0;
    end else begin
      rd2 <= rd2a;
      if (cs2 && !we2) rd2a <= mem2[a2];
    end
  end

  logic [1:0]   maddr;
  logic [3:0]   mbe;
  logic         mcs, mwe, msv, mbusy;
  logic [127:0] mflat;
  assign maddr = sel ? a2 : a1;
  assign mbe   = sel ? be2 : be1;
  assign mcs   = sel ? cs2 : cs1;
  assign mwe   = sel ? we2 : we1;
  assign msv   = sel ? sv2 : sv1;
  assign mbusy = sel ? busy2 : busy1;
  assign mflat = sel ? flat2 : flat1;

  task automatic pulse_sweep();
    @(negedge clk);
    if (sel) sweep_req2 = 1'b1; else sweep_req1 = 1'b1;
    @(negedge clk);
    sweep_req1 = 1'b0;
    sweep_req2 = 1'b0;
  endtask

  // Advance (bounded) to the first negedge showing a bus cycle of the given direction.
  task automatic wait_cs(input bit want_we, input string nm);
    int n = 0;
    while (!(mcs && mwe == want_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL %s: no bus cycle with write=%0d within 20 cycles", nm, want_we);
    end
  endtask

  // Called at the negedge where address 0 is on the bus.
  task automatic check_sweep(input int lat, input logic [127:0] exp, input string nm);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mcs, mwe, mbe, maddr} !== {1'b1, 1'b0, 4'hf, 2'(i)}) begin
        failures++;
        $display("FAIL %s issue%0d: got cs/we/be/addr=%b/%b/%h/%0d want 1/0/f/%0d",
                 nm, i, mcs, mwe, mbe, maddr, i);
      end
      @(negedge clk);
    end
    for (int k = 0; k < lat; k++) begin
      checks++;
      if (msv !== 1'b0 || mcs !== 1'b0 || mbusy !== 1'b1) begin
        failures++;
        $display("FAIL %s drain%0d: got sv/cs/busy=%b/%b/%b want 0/0/1", nm, k, msv, mcs, mbusy);
      end
      @(negedge clk);
    end
    checks++;
    if (msv !== 1'b1) begin
      failures++;
      $display("FAIL %s snap_valid: got %b want 1", nm, msv);
    end
    checks++;
    if (mflat !== exp) begin
      failures++;
      $display("FAIL %s snap_flat: got %h want %h", nm, mflat, exp);
    end
    @(negedge clk);
    checks++;
    if (msv !== 1'b0 || mbusy !== 1'b0) begin
      failures++;
      $display("FAIL %s after: got sv/busy=%b/%b want 0/0", nm, msv, mbusy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs1, we1, sv1, done1, busy1, ck1} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_ctrl: got cs/we/sv/done/busy/clken=%b%b%b%b%b%b want 000001",
               cs1, we1, sv1, done1, busy1, ck1);
    end
    checks++;
    if ({a1, be1, wd1} !== {2'd0, 4'hf, 32'h0}) begin
      failures++;
      $display("FAIL reset_bus: got addr/be/wdata=%0d/%h/%h want 0/f/0", a1, be1, wd1);
    end
    checks++;
    if (flat1 !== '0 || busy2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_snap: got flat=%h busy2=%b want 0/0", flat1, busy2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    pulse_sweep();
    wait_cs(1'b0, "sweep");
    check_sweep(1, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, "sweep");
  endtask

  task automatic test_write();
    @(negedge clk);
    wr_req1 = 1'b1; wr_addr1 = 2'd2; wr_data1 = 32'hDEADBEEF; wr_be1 = 4'b0011;
    @(negedge clk);
    wr_req1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; wr_be1 = '0;
    wait_cs(1'b1, "write");
    checks++;
    if ({be1, a1, wd1, done1, busy1} !== {4'b0011, 2'd2, 32'hDEADBEEF, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL write_bus: got be/addr/data/done/busy=%b/%0d/%h/%b/%b want 0011/2/deadbeef/1/1",
               be1, a1, wd1, done1, busy1);
    end
    @(negedge clk);
    checks++;
    if (cs1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL write_one_cycle: got cs/done=%b/%b want 0/0", cs1, done1);
    end
    pulse_sweep();
    wait_cs(1'b0, "write_sweep");
    check_sweep(1, {32'h44444444, 32'h3333BEEF, 32'h22222222, 32'h11111111}, "write_sweep");
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    sweep_req1 = 1'b1;
    wr_req1 = 1'b1; wr_addr1 = 2'd0; wr_data1 = 32'hCAFEF00D; wr_be1 = 4'hf;
    @(negedge clk);
    sweep_req1 = 1'b0; wr_req1 = 1'b0;
    wait_cs(1'b1, "simul_write");
    checks++;
    if (mcs !== 1'b1 || mwe !== 1'b1 || wd1 !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL simul_write_first: got cs/we/data=%b/%b/%h want 1/1/cafef00d", mcs, mwe, wd1);
    end
    @(negedge clk);
    wait_cs(1'b0, "simul_sweep");
    check_sweep(1, {32'h44444444, 32'h3333BEEF, 32'h22222222, 32'hCAFEF00D}, "simul_sweep");
  endtask

  task automatic test_merge();
    int nsv = 0;
    int ncs = 0;
    pulse_sweep();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      sweep_req1 = (c >= 1 && c <= 3);
      if (sv1) nsv++;
      if (cs1) ncs++;
    end
    sweep_req1 = 1'b0;
    checks++;
    if (nsv != 2) begin
      failures++;
      $display("FAIL merge_snap_valid: got %0d pulses want 2", nsv);
    end
    checks++;
    if (ncs != 8) begin
      failures++;
      $display("FAIL merge_reads: got %0d read cycles want 8", ncs);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    pulse_sweep();
    wait_cs(1'b0, "rst_mid");
    repeat (2) @(negedge clk);
    checks++;
    if (a1 !== 2'd2 || cs1 !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pos: got addr/cs=%0d/%b want 2/1", a1, cs1);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cs1 !== 1'b0 || busy1 !== 1'b0 || flat1 !== '0 || sv1 !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state: got cs/busy/sv=%b/%b/%b flat=%h want 0/0/0 flat=0",
               cs1, busy1, sv1, flat1);
    end
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (sv1 || cs1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rst_mid_abandon: got activity after reset want none");
    end
  endtask

  task automatic test_latency2();
    sel = 1'b1;
    pulse_sweep();
    wait_cs(1'b0, "lat2");
    check_sweep(2, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, "lat2");
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_write();
    test_simultaneous();
    test_merge();
    test_reset_mid();
    test_latency2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
